iter_mul_add: RTL
=================

ITER_MUL_ADD -- requirements
Module: iter_mul_add

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port Q, input, 6, unsigned multiplier (quotient operand).
REQ-004 SHALL have port B, input, 4, unsigned multiplicand (divisor operand).
REQ-005 SHALL have port R, input, 4, unsigned addend (remainder operand).
REQ-006 SHALL have port E, input, 1, level start/enable request.
REQ-007 SHALL have port P, output, 10, result Q*B+R, registered.
REQ-008 SHALL have port done, output, 1, result-valid level.
REQ-009 SHALL have port busy, output, 1, high while iterating.
REQ-010 SHALL have port err, output, 1, remainder-check flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ITER, DONE; no other reachable state.
REQ-012 SHALL, in IDLE with E=1 at a clock edge, capture Q, B, R: acc<=R, mcand<=B, mplier<=Q, cnt<=0, go to ITER.
REQ-013 SHALL, in IDLE with E=0, hold all registers and outputs.
REQ-014 SHALL, on each ITER edge, add (mcand << cnt) to acc when mplier[cnt]=1, then increment cnt; LSB first.
REQ-015 SHALL leave ITER after exactly 6 ITER edges (cnt=5 processed) and enter DONE.
REQ-016 SHALL compute all sums at 10 bits; max result 63*15+15=960, no overflow possible, no truncation.
REQ-017 SHALL drive P from acc and assert done=1 for every cycle in DONE; latency = 7 edges from capture edge to done high.
REQ-018 SHALL keep busy=1 exactly during ITER; busy and done never high together.
REQ-019 SHALL ignore E and input changes during ITER; operands are those captured at REQ-012.
REQ-020 SHALL stay in DONE while E=1; on edge with E=0 return to IDLE, drop done, keep P holding last result.
REQ-021 SHALL, with E held high continuously, not restart; a new operation requires E low for at least one edge (level handshake).
REQ-022 SHALL produce P=R when B=0 or Q=0, still taking full 7-edge latency.

Reset
REQ-023 SHALL, when reset=0, immediately (asynchronously) force IDLE, P=0, done=0, busy=0, err=0, acc/cnt/mplier/mcand=0.
REQ-024 SHALL abort any in-progress ITER on reset with no partial result visible after release.
REQ-025 SHALL resume sampling E on the first rising edge after reset returns to 1.

Configuration
REQ-026 SHALL use macro ITER_MUL_ADD_RCHK_EN.
REQ-027 SHALL, when defined, set err<=1 at the capture edge if R>=B (not a legal divider remainder), hold it until next capture or reset; P still computed.
REQ-028 SHALL, when undefined, tie err to constant 0 and include no compare logic; port list unchanged.

Structure
REQ-029 SHALL take widths QW=6, BW=4, PW=10, iteration count 6 and the FSM state encoding from shared package iter_div_pkg, also used by the divider.
REQ-030 SHALL contain FSM and datapath in one module; optional sub-module iter_mul_add_dp (shift-add accumulator) only if the FSM exceeds readability.

Verification
REQ-031 Q=5,B=3,R=2, E rises -> busy 6 cycles, done high on 7th edge, P=17, err=0.
REQ-032 Q=63,B=15,R=15 -> P=960; Q=0,B=9,R=4 -> P=4 after 7 edges.
REQ-033 E held high after done -> done stays 1, P=17 stable, no second run; E low one edge -> IDLE, done=0.
REQ-034 reset=0 at 3rd ITER cycle of Q=42,B=11,R=1 -> outputs zero at once; after release, rerun gives P=463.
REQ-035 RCHK_EN defined, Q=2,B=3,R=7 -> err=1, P=13; undefined -> err=0.
REQ-036 Round-trip: for B=1..15, A=0..63 feed divider Q,R into block -> P equals A every case.

Source files
------------

// File: rtl/iter_div_pkg.sv
// Shared widths and FSM encoding for the iterative multiply-add / divide blocks.
package iter_div_pkg;

    localparam int unsigned QW     = 6;   // quotient / multiplier width
    localparam int unsigned BW     = 4;   // divisor / multiplicand width
    localparam int unsigned PW     = 10;  // product / dividend width
    localparam int unsigned N_ITER = 6;   // one iteration per multiplier bit
    localparam int unsigned CW     = 3;   // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/iter_mul_add.sv
// Iterative shift-add multiplier computing P = Q*B + R, one multiplier bit per clock.
// Optional remainder check (R >= B flags err) enabled by macro ITER_MUL_ADD_RCHK_EN.
module iter_mul_add
    import iter_div_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [QW-1:0] Q,
    input  logic [BW-1:0] B,
    input  logic [BW-1:0] R,
    input  logic          E,
    output logic [PW-1:0] P,
    output logic          done,
    output logic          busy,
    output logic          err
);

    state_e        state_q,  state_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic [BW-1:0] mcand_q,  mcand_d;
    logic [QW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] p_q,      p_d;
    logic          done_q,   done_d;
    logic          busy_q,   busy_d;
`ifdef ITER_MUL_ADD_RCHK_EN
    logic          err_q,    err_d;
`endif

    // State and datapath registers; reset aborts any run and clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ITER_MUL_ADD_RCHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef ITER_MUL_ADD_RCHK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and datapath: capture on E, add shifted multiplicand per set bit, publish in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        done_d   = done_q;
        busy_d   = busy_q;
`ifdef ITER_MUL_ADD_RCHK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (E) begin
                    acc_d    = PW'(R);
                    mcand_d  = B;
                    mplier_d = Q;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
`ifdef ITER_MUL_ADD_RCHK_EN
                    err_d    = (R >= B);
`endif
                    state_d  = ITER;
                end
            end
            ITER: begin
                if (mplier_q[cnt_q]) begin
                    acc_d = acc_q + (PW'(mcand_q) << cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_ITER - 1)) begin
                    p_d     = acc_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Level handshake: stay until E drops so a held E cannot restart.
                if (!E) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign P    = p_q;
    assign done = done_q;
    assign busy = busy_q;
`ifdef ITER_MUL_ADD_RCHK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule
